// File: rtl/matrix_op_engine_if.sv
// rtl/matrix_op_engine_if.sv - storage port between the matrix engine and the storage MUX
interface matrix_op_engine_if #(
  parameter int DW = 32,
  parameter int AW = 8
) ();
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // engine side drives the registered request, storage answers one cycle later
  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/matrix_op_engine.sv
// rtl/matrix_op_engine.sv - matrix transpose/add/scale/multiply/convolve engine over shared storage
module matrix_op_engine #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int MAX_DIM = 5,
  parameter int A_BASE  = 0,
  parameter int B_BASE  = 32,
  parameter int C_BASE  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [DW-1:0]       scalar,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         cycle_cnt,
  matrix_op_engine_if.master  bus
);

  localparam int REGION = MAX_DIM * MAX_DIM + 2;
  localparam int IW     = $clog2(MAX_DIM + 1);
  localparam int SPACE  = 2 ** AW;

  localparam logic [2:0] OP_TRANS  = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SCALAR = 3'd2;
  localparam logic [2:0] OP_MULT   = 3'd3;
  localparam logic [2:0] OP_CONV   = 3'd4;

  // Each matrix region must hold a full MAX_DIM x MAX_DIM matrix plus its header
  // without colliding with another region or running off the address space.
  localparam bit AB_OK = (A_BASE + REGION <= B_BASE) || (B_BASE + REGION <= A_BASE);
  localparam bit AC_OK = (A_BASE + REGION <= C_BASE) || (C_BASE + REGION <= A_BASE);
  localparam bit BC_OK = (B_BASE + REGION <= C_BASE) || (C_BASE + REGION <= B_BASE);
  localparam bit FIT_OK = (A_BASE >= 0) && (B_BASE >= 0) && (C_BASE >= 0) &&
                          (A_BASE + REGION <= SPACE) && (B_BASE + REGION <= SPACE) &&
                          (C_BASE + REGION <= SPACE);

  if (!(AB_OK && AC_OK && BC_OK && FIT_OK)) begin : g_region_check
    $error("matrix_op_engine: matrix regions overlap or exceed the address space");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_CHECK,
    S_WDIM,
    S_FETCH_A,
    S_FETCH_B,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [1:0]    hdr_idx_q, hdr_idx_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] scalar_q, scalar_d;
  logic [DW-1:0] a_rows_q, a_rows_d, a_cols_q, a_cols_d;
  logic [DW-1:0] b_rows_q, b_rows_d, b_cols_q, b_cols_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, u_q, u_d, v_q, v_d;
  logic [DW-1:0] acc_q, acc_d, a_hold_q, a_hold_d;
  logic [31:0]   run_cnt_q, run_cnt_d, cycle_cnt_q, cycle_cnt_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  // narrow views of the header, only meaningful once the dimensions are validated
  logic [IW-1:0] am, an, bm, bn, c_rows, c_cols;
  logic [IW-1:0] i_nx, j_nx, u_nx, v_nx;
  logic          last_inner, last_elem, dims_bad;
  logic [DW-1:0] prod, sum, scaled;

  function automatic logic dim_ok(input logic [DW-1:0] x);
    return (x != '0) && (x <= DW'(MAX_DIM));
  endfunction

  // address of the A operand for the given C element / inner index
  function automatic logic [AW-1:0] a_addr(input logic [2:0] o, input logic [IW-1:0] ii,
                                           input logic [IW-1:0] jj, input logic [IW-1:0] uu,
                                           input logic [IW-1:0] vv, input logic [IW-1:0] ncols);
    int r, c;
    case (o)
      OP_TRANS: begin r = int'(jj); c = int'(ii); end
      OP_MULT:  begin r = int'(ii); c = int'(uu); end
      OP_CONV:  begin r = int'(ii) + int'(uu); c = int'(jj) + int'(vv); end
      default:  begin r = int'(ii); c = int'(jj); end
    endcase
    return AW'(A_BASE + 2 + r * int'(ncols) + c);
  endfunction

  // address of the B operand for the given C element / inner index
  function automatic logic [AW-1:0] b_addr(input logic [2:0] o, input logic [IW-1:0] ii,
                                           input logic [IW-1:0] jj, input logic [IW-1:0] uu,
                                           input logic [IW-1:0] vv, input logic [IW-1:0] ncols);
    int r, c;
    case (o)
      OP_MULT: begin r = int'(uu); c = int'(jj); end
      OP_CONV: begin r = int'(uu); c = int'(vv); end
      default: begin r = int'(ii); c = int'(jj); end
    endcase
    return AW'(B_BASE + 2 + r * int'(ncols) + c);
  endfunction

  function automatic logic [AW-1:0] c_addr(input logic [IW-1:0] ii, input logic [IW-1:0] jj,
                                           input logic [IW-1:0] ncols);
    return AW'(C_BASE + 2 + int'(ii) * int'(ncols) + int'(jj));
  endfunction

  // result shape, dimension legality and loop-index successors
  always_comb begin
    am = a_rows_q[IW-1:0];
    an = a_cols_q[IW-1:0];
    bm = b_rows_q[IW-1:0];
    bn = b_cols_q[IW-1:0];

    case (op_q)
      OP_TRANS: begin c_rows = an; c_cols = am; end
      OP_MULT:  begin c_rows = am; c_cols = bn; end
      OP_CONV:  begin c_rows = am - bm + IW'(1); c_cols = an - bn + IW'(1); end
      default:  begin c_rows = am; c_cols = an; end
    endcase

    case (op_q)
      OP_TRANS, OP_SCALAR: dims_bad = !(dim_ok(a_rows_q) && dim_ok(a_cols_q));
      OP_ADD:  dims_bad = !(dim_ok(a_rows_q) && dim_ok(a_cols_q) && dim_ok(b_rows_q) &&
                            dim_ok(b_cols_q) && (a_rows_q == b_rows_q) && (a_cols_q == b_cols_q));
      OP_MULT: dims_bad = !(dim_ok(a_rows_q) && dim_ok(a_cols_q) && dim_ok(b_rows_q) &&
                            dim_ok(b_cols_q) && (a_cols_q == b_rows_q));
      OP_CONV: dims_bad = !(dim_ok(a_rows_q) && dim_ok(a_cols_q) && dim_ok(b_rows_q) &&
                            dim_ok(b_cols_q) && (b_rows_q <= a_rows_q) && (b_cols_q <= a_cols_q));
      default: dims_bad = 1'b1;
    endcase

    last_elem = (i_q == c_rows - IW'(1)) && (j_q == c_cols - IW'(1));
    if (j_q == c_cols - IW'(1)) begin
      i_nx = i_q + IW'(1);
      j_nx = '0;
    end else begin
      i_nx = i_q;
      j_nx = j_q + IW'(1);
    end

    if (op_q == OP_CONV) begin
      last_inner = (u_q == bm - IW'(1)) && (v_q == bn - IW'(1));
      if (v_q == bn - IW'(1)) begin
        u_nx = u_q + IW'(1);
        v_nx = '0;
      end else begin
        u_nx = u_q;
        v_nx = v_q + IW'(1);
      end
    end else begin
      last_inner = (u_q == an - IW'(1));
      u_nx = u_q + IW'(1);
      v_nx = '0;
    end

    prod   = a_hold_q * bus.mem_rdata;
    sum    = acc_q + prod;
    scaled = bus.mem_rdata * scalar_q;
  end

  // sequencer: every storage request and status output is computed one cycle ahead
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hdr_idx_d   = hdr_idx_q;
    op_d        = op_q;
    scalar_d    = scalar_q;
    a_rows_d    = a_rows_q;
    a_cols_d    = a_cols_q;
    b_rows_d    = b_rows_q;
    b_cols_d    = b_cols_q;
    i_d         = i_q;
    j_d         = j_q;
    u_d         = u_q;
    v_d         = v_q;
    acc_d       = acc_q;
    a_hold_d    = a_hold_q;
    run_cnt_d   = (state_q == S_IDLE) ? run_cnt_q : run_cnt_q + 32'd1;
    cycle_cnt_d = cycle_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          phase_d    = 1'b0;
          hdr_idx_d  = 2'd0;
          op_d       = op;
          scalar_d   = scalar;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          run_cnt_d  = 32'd1;
          mem_addr_d = AW'(A_BASE);
        end
      end

      S_HDR: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d   = 1'b0;
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd0: begin a_rows_d = bus.mem_rdata; mem_addr_d = AW'(A_BASE + 1); end
            2'd1: begin a_cols_d = bus.mem_rdata; mem_addr_d = AW'(B_BASE); end
            2'd2: begin b_rows_d = bus.mem_rdata; mem_addr_d = AW'(B_BASE + 1); end
            default: begin b_cols_d = bus.mem_rdata; state_d = S_CHECK; end
          endcase
        end
      end

      S_CHECK: begin
        if (dims_bad) begin
          state_d     = S_DONE;
          err_d       = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cycle_cnt_d = run_cnt_q + 32'd1;
        end else begin
          state_d     = S_WDIM;
          phase_d     = 1'b0;
          mem_we_d    = 1'b1;
          mem_addr_d  = AW'(C_BASE);
          mem_wdata_d = DW'(c_rows);
        end
      end

      S_WDIM: begin
        if (!phase_q) begin
          phase_d     = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = AW'(C_BASE + 1);
          mem_wdata_d = DW'(c_cols);
        end else begin
          state_d    = S_FETCH_A;
          phase_d    = 1'b0;
          i_d        = '0;
          j_d        = '0;
          u_d        = '0;
          v_d        = '0;
          acc_d      = '0;
          mem_addr_d = a_addr(op_q, '0, '0, '0, '0, an);
        end
      end

      S_FETCH_A: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (op_q == OP_TRANS || op_q == OP_SCALAR) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = c_addr(i_q, j_q, c_cols);
            mem_wdata_d = (op_q == OP_SCALAR) ? scaled : bus.mem_rdata;
          end else begin
            state_d    = S_FETCH_B;
            a_hold_d   = bus.mem_rdata;
            mem_addr_d = b_addr(op_q, i_q, j_q, u_q, v_q, bn);
          end
        end
      end

      S_FETCH_B: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (op_q == OP_ADD) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = c_addr(i_q, j_q, c_cols);
            mem_wdata_d = a_hold_q + bus.mem_rdata;
          end else if (last_inner) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = c_addr(i_q, j_q, c_cols);
            mem_wdata_d = sum;
          end else begin
            state_d    = S_FETCH_A;
            acc_d      = sum;
            u_d        = u_nx;
            v_d        = v_nx;
            mem_addr_d = a_addr(op_q, i_q, j_q, u_nx, v_nx, an);
          end
        end
      end

      S_WRITE: begin
        if (last_elem) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cycle_cnt_d = run_cnt_q + 32'd1;
        end else begin
          state_d    = S_FETCH_A;
          phase_d    = 1'b0;
          i_d        = i_nx;
          j_d        = j_nx;
          u_d        = '0;
          v_d        = '0;
          acc_d      = '0;
          mem_addr_d = a_addr(op_q, i_nx, j_nx, '0, '0, an);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      hdr_idx_q   <= 2'd0;
      op_q        <= 3'd0;
      scalar_q    <= '0;
      a_rows_q    <= '0;
      a_cols_q    <= '0;
      b_rows_q    <= '0;
      b_cols_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      u_q         <= '0;
      v_q         <= '0;
      acc_q       <= '0;
      a_hold_q    <= '0;
      run_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hdr_idx_q   <= hdr_idx_d;
      op_q        <= op_d;
      scalar_q    <= scalar_d;
      a_rows_q    <= a_rows_d;
      a_cols_q    <= a_cols_d;
      b_rows_q    <= b_rows_d;
      b_cols_q    <= b_cols_d;
      i_q         <= i_d;
      j_q         <= j_d;
      u_q         <= u_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      a_hold_q    <= a_hold_d;
      run_cnt_q   <= run_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_matrix_op_engine.sv
// tb/tb_matrix_op_engine.sv - directed bench for matrix_op_engine with a storage model
module tb_matrix_op_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] scalar;
  logic        busy, done, err;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  int we_total = 0;

  logic        tb_we;
  logic [7:0]  tb_addr;
  logic [31:0] tb_wdata;
  logic [31:0] mem [0:255];
  logic [31:0] rdata_q;

  matrix_op_engine_if #(.DW(32), .AW(8)) bus ();

  matrix_op_engine #(
    .DW(32), .AW(8), .MAX_DIM(5), .A_BASE(0), .B_BASE(32), .C_BASE(64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .scalar    (scalar),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cycle_cnt (cycle_cnt),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous storage: read data appears the cycle after the address
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
    rdata_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) we_total <= we_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    @(negedge clk);
    tb_we    = 1'b1;
    tb_addr  = 8'(addr);
    tb_wdata = 32'(data);
    @(negedge clk);
    tb_we    = 1'b0;
  endtask

  task automatic load_mat(input int base, input int rows, input int cols, input int v[9]);
    wr(base, rows);
    wr(base + 1, cols);
    for (int k = 0; k < rows * cols && k < 9; k++) wr(base + 2 + k, v[k]);
  endtask

  task automatic check_c(input string tag, input int rows, input int cols, input int v[9]);
    check({tag, " c_rows"}, mem[64], 32'(rows));
    check({tag, " c_cols"}, mem[65], 32'(cols));
    for (int k = 0; k < rows * cols; k++)
      check($sformatf("%s c[%0d]", tag, k), mem[66 + k], 32'(v[k]));
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] s,
                        input int exp_t, input logic exp_err, input int exp_we);
    int n;
    int we0;
    bit seen;
    @(negedge clk);
    op     = o;
    scalar = s;
    start  = 1'b1;
    we0    = we_total;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy after accept"}, busy, 1);
    seen = 1'b0;
    while (!seen && n < 300) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    check({tag, " done seen"}, seen, 1);
    check({tag, " done cycle"}, n, exp_t);
    check({tag, " cycle_cnt"}, cycle_cnt, exp_t);
    check({tag, " err"}, err, exp_err);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " write count"}, we_total - we0, exp_we);
    @(negedge clk);
    check({tag, " done pulse width"}, done, 0);
    check({tag, " err held"}, err, exp_err);
  endtask

  initial begin
    int we0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 3'd0;
    scalar   = 32'd0;
    tb_we    = 1'b0;
    tb_addr  = 8'd0;
    tb_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset mem_we", bus.mem_we, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset mem_wdata", bus.mem_wdata, 0);
    check("reset cycle_cnt", cycle_cnt, 0);
    rst_n = 1'b1;

    // transpose of 2x3
    load_mat(0, 2, 3, '{1, 2, 3, 4, 5, 6, 0, 0, 0});
    load_mat(32, 3, 2, '{7, 8, 9, 10, 11, 12, 0, 0, 0});
    run_op("transpose", 3'd0, 32'd0, 30, 1'b0, 8);
    check_c("transpose", 3, 2, '{1, 4, 2, 5, 3, 6, 0, 0, 0});

    // matrix multiply 2x3 * 3x2
    run_op("mult", 3'd3, 32'd0, 64, 1'b0, 6);
    check_c("mult", 2, 2, '{58, 64, 139, 154, 0, 0, 0, 0, 0});

    // scalar by all-ones wraps to negation
    run_op("scalar", 3'd2, 32'hFFFF_FFFF, 30, 1'b0, 8);
    check_c("scalar", 2, 3, '{-1, -2, -3, -4, -5, -6, 0, 0, 0});

    // element-wise add
    load_mat(0, 2, 2, '{1, 2, 3, 4, 0, 0, 0, 0, 0});
    load_mat(32, 2, 2, '{5, 6, 7, 8, 0, 0, 0, 0, 0});
    run_op("add", 3'd1, 32'd0, 32, 1'b0, 6);
    check_c("add", 2, 2, '{6, 8, 10, 12, 0, 0, 0, 0, 0});

    // valid-mode convolution with 2x2 diagonal kernel
    load_mat(0, 3, 3, '{1, 2, 3, 4, 5, 6, 7, 8, 9});
    load_mat(32, 2, 2, '{1, 0, 0, 1, 0, 0, 0, 0, 0});
    run_op("conv", 3'd4, 32'd0, 80, 1'b0, 6);
    check_c("conv", 2, 2, '{6, 8, 12, 14, 0, 0, 0, 0, 0});

    // dimension and opcode errors
    load_mat(0, 2, 3, '{1, 2, 3, 4, 5, 6, 0, 0, 0});
    load_mat(32, 2, 2, '{1, 2, 3, 4, 0, 0, 0, 0, 0});
    run_op("err mult shape", 3'd3, 32'd0, 10, 1'b1, 0);
    wr(0, 6);
    wr(1, 2);
    run_op("err dim 6", 3'd0, 32'd0, 10, 1'b1, 0);
    load_mat(0, 2, 2, '{1, 2, 3, 4, 0, 0, 0, 0, 0});
    run_op("err op 6", 3'd6, 32'd0, 10, 1'b1, 0);

    // reset in the middle of a multiply
    load_mat(0, 2, 3, '{1, 2, 3, 4, 5, 6, 0, 0, 0});
    load_mat(32, 3, 2, '{7, 8, 9, 10, 11, 12, 0, 0, 0});
    @(negedge clk);
    op    = 3'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("mid-op busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort err", err, 0);
    check("abort mem_we", bus.mem_we, 0);
    check("abort mem_addr", bus.mem_addr, 0);
    check("abort mem_wdata", bus.mem_wdata, 0);
    check("abort cycle_cnt", cycle_cnt, 0);
    we0 = we_total;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort no writes", we_total - we0, 0);
    rst_n = 1'b1;

    // fresh add after abort
    for (int k = 64; k < 70; k++) wr(k, 0);
    load_mat(0, 2, 2, '{1, 2, 3, 4, 0, 0, 0, 0, 0});
    load_mat(32, 2, 2, '{5, 6, 7, 8, 0, 0, 0, 0, 0});
    run_op("add after reset", 3'd1, 32'd0, 32, 1'b0, 6);
    check_c("add after reset", 2, 2, '{6, 8, 10, 12, 0, 0, 0, 0, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
